mat_row_loader: RTL and testbench

- Upstream feeder for MatCache. It accepts a scalar stream of shortreal elements over a valid/ready handshake and packs them row-major into WIDTH-wide rows.
- Each completed row is issued as a MAT_CACHE_WRITE_ROW op into one CACHE_SIZE slot.
- Rows beyond the requested count are zero-filled so every loaded matrix is fully defined.
- The command side (start/addr/num_rows) comes from the instruction decoder.

---
 rtl/mat_pkg.sv | 24 ++
 rtl/mat_row_loader.sv | 153 +++++++++++++++
 tb/tb_mat_row_loader.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mat_pkg.sv
// Shared types for the MatCache write path and the row loader FSM.
package mat_pkg;

  // IEEE-754 single-precision element carried as its raw bit pattern.
  typedef logic [31:0] fp32_t;

  localparam fp32_t FP32_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    MAT_CACHE_WRITE_NONE,
    MAT_CACHE_WRITE_ROW,
    MAT_CACHE_WRITE_COL,
    MAT_CACHE_WRITE_MATRIX
  } MatCacheWriteOp_t;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    WRITE,
    PAD,
    DONE
  } MatLoaderState_t;

endpackage

// File: rtl/mat_row_loader.sv
// Packs a scalar element stream row-major into WIDTH-wide rows and issues
// one MatCache row write per completed row; rows past num_rows are zeroed.
module mat_row_loader
  import mat_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int CACHE_SIZE = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [$clog2(CACHE_SIZE)-1:0] start_addr,
  input  logic [$clog2(WIDTH):0]        num_rows,
  input  fp32_t                         in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output MatCacheWriteOp_t              write_op,
  output logic [$clog2(CACHE_SIZE)-1:0] write_addr1,
  output logic [$clog2(CACHE_SIZE)-1:0] write_addr2,
  output logic [$clog2(WIDTH)-1:0]      write_param,
  output fp32_t [WIDTH-1:0]             data_out,
  output logic                          busy,
  output logic                          done
);

  localparam int CW = $clog2(WIDTH);
  localparam int AW = $clog2(CACHE_SIZE);
  localparam int NW = CW + 1;

  MatLoaderState_t   state, state_n;
  logic [CW-1:0]     col, col_n, row, row_n;
  logic [NW-1:0]     row_inc, nrows_q, nrows_clamped;
  logic [AW-1:0]     addr_q;
  fp32_t [WIDTH-1:0] buf_q;
  logic              xfer;

  // Next-cycle values of the registered outputs
  logic              in_ready_n, busy_n, done_n;
  MatCacheWriteOp_t  write_op_n;
  logic [AW-1:0]     write_addr1_n;
  logic [CW-1:0]     write_param_n;
  fp32_t [WIDTH-1:0] data_n;

  assign xfer          = (state == FILL) && in_valid && in_ready;
  assign row_inc       = {1'b0, row} + NW'(1);
  assign nrows_clamped = (num_rows == '0 || num_rows > NW'(WIDTH)) ? NW'(WIDTH) : num_rows;
  assign write_addr2   = '0;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state and counter updates
  always_comb begin
    state_n = state;
    col_n   = col;
    row_n   = row;
    case (state)
      IDLE: if (start) begin
        state_n = FILL;
        col_n   = '0;
        row_n   = '0;
      end
      FILL: if (xfer) begin
        if (col == CW'(WIDTH - 1)) begin
          state_n = WRITE;
          col_n   = '0;
        end else begin
          col_n = col + CW'(1);
        end
      end
      WRITE: begin
        // Stop advancing row on the last write so it never wraps mid-matrix
        if (row_inc < nrows_q) begin
          state_n = FILL;
          row_n   = row_inc[CW-1:0];
        end else if (row_inc < NW'(WIDTH)) begin
          state_n = PAD;
          row_n   = row_inc[CW-1:0];
        end else begin
          state_n = DONE;
        end
      end
      PAD: begin
        if (row == CW'(WIDTH - 1)) state_n = DONE;
        else                       row_n   = row_inc[CW-1:0];
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs derived from the upcoming state, then registered
  always_comb begin
    in_ready_n    = (state_n == FILL);
    busy_n        = (state_n != IDLE);
    done_n        = (state_n == DONE);
    write_op_n    = MAT_CACHE_WRITE_NONE;
    write_addr1_n = '0;
    write_param_n = '0;
    data_n        = '0;
    if (state_n == WRITE || state_n == PAD) begin
      write_op_n    = MAT_CACHE_WRITE_ROW;
      write_addr1_n = addr_q;
      write_param_n = row_n;
    end
    // WRITE is only entered on the transfer that completes the row, so
    // the final element is forwarded straight from the input.
    if (state_n == WRITE) begin
      data_n      = buf_q;
      data_n[col] = in_data;
    end
  end

  // Counters, command latch and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      col         <= '0;
      row         <= '0;
      addr_q      <= '0;
      nrows_q     <= '0;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      write_op    <= MAT_CACHE_WRITE_NONE;
      write_addr1 <= '0;
      write_param <= '0;
      data_out    <= '0;
    end else begin
      col <= col_n;
      row <= row_n;
      if (state == IDLE && start) begin
        addr_q  <= start_addr;
        nrows_q <= nrows_clamped;
      end
      in_ready    <= in_ready_n;
      busy        <= busy_n;
      done        <= done_n;
      write_op    <= write_op_n;
      write_addr1 <= write_addr1_n;
      write_param <= write_param_n;
      data_out    <= data_n;
    end
  end

  // Row buffer; stale entries are always overwritten before the next write
  always_ff @(posedge clock) begin
    if (xfer) buf_q[col] <= in_data;
  end

endmodule

// File: tb/tb_mat_row_loader.sv
// Self-checking bench for mat_row_loader: captures every row write and
// compares it with an expected matrix built from the streamed elements.
module tb_mat_row_loader;
  import mat_pkg::*;

  localparam int W  = 4;
  localparam int CS = 4;

  logic             clock = 1'b0;
  logic             reset, start, in_valid, in_ready, busy, done;
  logic [1:0]       start_addr, write_addr1, write_addr2, write_param;
  logic [2:0]       num_rows;
  fp32_t            in_data;
  MatCacheWriteOp_t write_op;
  fp32_t [W-1:0]    data_out;

  mat_row_loader #(.WIDTH(W), .CACHE_SIZE(CS)) dut (
    .clock(clock), .reset(reset), .start(start), .start_addr(start_addr),
    .num_rows(num_rows), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .write_op(write_op), .write_addr1(write_addr1),
    .write_addr2(write_addr2), .write_param(write_param),
    .data_out(data_out), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0, n_fail = 0;
  fp32_t elems [W*W];

  // Write / done monitor, sampled on the falling edge
  int               w_tag[$], w_param[$], w_addr[$], w_addr2[$], d_tag[$];
  logic [W*32-1:0]  w_data[$];
  int               bad_ready = 0, bad_op = 0;

  always @(negedge clock) begin
    if (reset !== 1'b1) begin
      if (write_op === MAT_CACHE_WRITE_ROW) begin
        w_tag.push_back(cyc);
        w_param.push_back(int'(write_param));
        w_addr.push_back(int'(write_addr1));
        w_addr2.push_back(int'(write_addr2));
        w_data.push_back(data_out);
        if (in_ready !== 1'b0) bad_ready++;
      end else if (write_op !== MAT_CACHE_WRITE_NONE) begin
        bad_op++;
      end
      if (done === 1'b1) d_tag.push_back(cyc);
    end
  end

  task automatic clear_mon();
    w_tag.delete(); w_param.delete(); w_addr.delete(); w_addr2.delete();
    w_data.delete(); d_tag.delete();
    bad_ready = 0; bad_op = 0;
  endtask

  // Small non-negative integer to single-precision bit pattern
  function automatic fp32_t i2f(input int n);
    int e;
    if (n == 0) return FP32_ZERO;
    e = 0;
    for (int b = 0; b < 24; b++) if (((n >> b) & 1) == 1) e = b;
    return {1'b0, 8'(127 + e), 23'((n << (23 - e)) & 32'h7F_FFFF)};
  endfunction

  // Reference matrix: streamed rows first, zero rows after the clamped count
  function automatic logic [W*32-1:0] exp_row(input int k, input int neff);
    logic [W*32-1:0] r;
    r = '0;
    if (k < neff)
      for (int c = 0; c < W; c++) r[c*32 +: 32] = elems[k*W + c];
    return r;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < W*W; i++) elems[i] = fp32_t'($urandom);
  endtask

  // mode 0: continuous valid, 1: valid every other cycle, 2: random valid
  task automatic test_load(input string name, input int addr, input int nr,
                           input int mode, input bit poke_start);
    int neff, ne, st, idx, guard, nw;
    bit v, acc;
    neff = (nr == 0 || nr > W) ? W : nr;
    ne   = neff * W;
    clear_mon();
    start = 1'b1; start_addr = 2'(addr); num_rows = 3'(nr);
    @(negedge clock);
    st = cyc;
    start = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s ready_latency: got %b expected 1", name, in_ready);
    end
    idx = 0; guard = 0;
    while (idx < ne && guard < 2000) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? ((guard % 2) == 0) : 1'($urandom_range(0, 1));
      in_valid = v;
      in_data  = elems[idx];
      if (poke_start && idx == 3) begin start = 1'b1; start_addr = 2'd3; num_rows = 3'd1; end
      else start = 1'b0;
      acc = v && (in_ready === 1'b1);
      @(negedge clock);
      guard++;
      if (acc) idx++;
    end
    in_valid = 1'b0; start = 1'b0;
    n_checks++;
    if (idx != ne) begin
      n_fail++; $display("FAIL %s stream_timeout: accepted %0d expected %0d", name, idx, ne);
    end
    guard = 0;
    while (d_tag.size() == 0 && guard < 100) begin @(negedge clock); guard++; end
    repeat (3) @(negedge clock);

    nw = w_tag.size();
    n_checks++;
    if (nw != W) begin
      n_fail++; $display("FAIL %s write_count: got %0d expected %0d", name, nw, W);
    end
    for (int k = 0; k < nw && k < W; k++) begin
      n_checks++;
      if (w_param[k] != k || w_addr[k] != addr || w_addr2[k] != 0) begin
        n_fail++;
        $display("FAIL %s write%0d_meta: got param %0d addr %0d addr2 %0d expected param %0d addr %0d addr2 0",
                 name, k, w_param[k], w_addr[k], w_addr2[k], k, addr);
      end
      n_checks++;
      if (w_data[k] !== exp_row(k, neff)) begin
        n_fail++;
        $display("FAIL %s write%0d_data: got %h expected %h", name, k, w_data[k], exp_row(k, neff));
      end
      if (k >= neff && k > 0) begin
        n_checks++;
        if (w_tag[k] != w_tag[k-1] + 1) begin
          n_fail++;
          $display("FAIL %s pad%0d_spacing: got gap %0d expected 1", name, k, w_tag[k] - w_tag[k-1]);
        end
      end
    end
    n_checks++;
    if (d_tag.size() != 1) begin
      n_fail++; $display("FAIL %s done_pulses: got %0d expected 1", name, d_tag.size());
    end else if (nw == W) begin
      n_checks++;
      if (d_tag[0] != w_tag[W-1] + 1) begin
        n_fail++; $display("FAIL %s done_after_last_write: got gap %0d expected 1", name, d_tag[0] - w_tag[W-1]);
      end
      if (mode == 0 && neff == W) begin
        n_checks++;
        if (d_tag[0] - st != W*(W+1)) begin
          n_fail++; $display("FAIL %s done_latency: got %0d expected %0d", name, d_tag[0] - st, W*(W+1));
        end
      end
    end
    n_checks++;
    if (bad_ready != 0 || bad_op != 0) begin
      n_fail++; $display("FAIL %s write_cycle_rules: ready_in_write %0d bad_op %0d expected 0 0", name, bad_ready, bad_op);
    end
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL %s idle_after: busy %b in_ready %b expected 0 0", name, busy, in_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; start_addr = '0; num_rows = '0;
    in_valid = 1'b0; in_data = '0;
    repeat (2) @(negedge clock);
    n_checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: ready %b busy %b done %b expected 0 0 0", in_ready, busy, done);
    end
    n_checks++;
    if (write_op !== MAT_CACHE_WRITE_NONE || write_addr1 !== 2'd0 || write_addr2 !== 2'd0 || write_param !== 2'd0) begin
      n_fail++; $display("FAIL reset_write: op %0d a1 %0d a2 %0d param %0d expected all 0",
                         write_op, write_addr1, write_addr2, write_param);
    end
    n_checks++;
    if (data_out !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", data_out);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_full_load();
    int vals[16] = '{4,6,1,6, 1,2,3,4, 3,3,3,3, 9,7,5,3};
    for (int i = 0; i < W*W; i++) elems[i] = i2f(vals[i]);
    test_load("full_load", 2, 4, 0, 1'b0);
  endtask

  task automatic test_partial();
    for (int i = 0; i < W*W; i++) elems[i] = i2f(i + 1);
    test_load("partial", 1, 2, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    int vals[16] = '{4,6,1,6, 1,2,3,4, 3,3,3,3, 9,7,5,3};
    for (int i = 0; i < W*W; i++) elems[i] = i2f(vals[i]);
    test_load("backpressure", 2, 4, 1, 1'b0);
  endtask

  task automatic test_clamp();
    fill_random();
    test_load("clamp_zero", 0, 0, 0, 1'b0);
    fill_random();
    test_load("clamp_seven", 3, 7, 0, 1'b0);
  endtask

  task automatic test_start_busy();
    fill_random();
    test_load("start_busy", 1, 4, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    int idx, guard;
    bit acc;
    fill_random();
    clear_mon();
    start = 1'b1; start_addr = 2'd2; num_rows = 3'd4;
    @(negedge clock);
    start = 1'b0;
    idx = 0; guard = 0;
    while (idx < 6 && guard < 100) begin
      in_valid = 1'b1; in_data = elems[idx];
      acc = (in_ready === 1'b1);
      @(negedge clock);
      guard++;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if (busy !== 1'b0 || write_op !== MAT_CACHE_WRITE_NONE || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_state: busy %b op %0d ready %b expected 0 0 0", busy, write_op, in_ready);
    end
    reset = 1'b0;
    repeat (6) @(negedge clock);
    n_checks++;
    if (w_tag.size() != 1 || d_tag.size() != 0) begin
      n_fail++; $display("FAIL reset_mid_writes: got writes %0d dones %0d expected 1 0", w_tag.size(), d_tag.size());
    end
    fill_random();
    test_load("after_reset", 0, 4, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 4; t++) begin
      fill_random();
      test_load("random", int'($urandom_range(0, CS-1)), int'($urandom_range(0, 7)), 2, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_partial();
    test_backpressure();
    test_clamp();
    test_start_busy();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
